reg_writeback: RTL and testbench

- Write-side front end for the 16 x 8-bit CPU register file.
- Merges two result producers onto the single register-file write port (we/dst/data):
  - ALU results, which can be back-pressured.
  - Memory load results, which cannot be stalled.
- Buffers deferred ALU results in a small FIFO.
- Provides a forwarding lookup so operand fetch sees values still pending write.

---
 rtl/reg_writeback.sv | 149 ++++++++++++++
 tb/tb_reg_writeback.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Merges non-stallable load results and back-pressured ALU results onto one register-file write port.
// Latency: 1 cycle from selection to we/dst/data; deferred ALU results wait in a DEPTH-entry FIFO.
// Backpressure: alu_ready = registered occupancy < DEPTH; loads always win and are never stalled.
// Optional: define WB_R0_ZERO_EN to make register 0 read-as-zero (writes consumed but suppressed).
module reg_writeback #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alu_valid,
   output logic             alu_ready,
   input  logic [3:0]       alu_dst,
   input  logic [7:0]       alu_data,
   input  logic             mem_valid,
   input  logic [3:0]       mem_dst,
   input  logic [7:0]       mem_data,
   output logic             we,
   output logic [3:0]       dst,
   output logic [7:0]       data,
   input  logic [3:0]       fwd_src,
   output logic             fwd_hit,
   output logic [7:0]       fwd_data,
   output logic [PTR_W:0]   pend_cnt
);

   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

   logic [3:0]       q_dst [DEPTH];
   logic [7:0]       q_dat [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   cnt;

   logic             acc;
   logic             fifo_ne;
   logic             pop;
   logic             bypass;
   logic             push;
   logic             sel_vld;
   logic [3:0]       sel_dst;
   logic [7:0]       sel_data;
   logic             wr_en;

   // Ready depends only on the start-of-cycle count, so a full FIFO stays closed even while popping.
   assign alu_ready = (cnt < FULL);
   assign pend_cnt  = cnt;

   assign acc     = alu_valid & alu_ready;
   assign fifo_ne = (cnt != '0);
   assign pop     = ~mem_valid & fifo_ne;
   assign bypass  = ~mem_valid & ~fifo_ne & acc;
   assign push    = acc & ~bypass;

   // Write-port arbitration: load, then FIFO head, then direct ALU bypass.
   always_comb begin
      sel_vld  = 1'b0;
      sel_dst  = mem_dst;
      sel_data = mem_data;
      if (mem_valid) begin
         sel_vld = 1'b1;
      end else if (fifo_ne) begin
         sel_vld  = 1'b1;
         sel_dst  = q_dst[head];
         sel_data = q_dat[head];
      end else if (acc) begin
         sel_vld  = 1'b1;
         sel_dst  = alu_dst;
         sel_data = alu_data;
      end
   end

`ifdef WB_R0_ZERO_EN
   assign wr_en = sel_vld & (sel_dst != 4'd0);
`else
   assign wr_en = sel_vld;
`endif

   // Output register; address/data hold when no write is issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we   <= 1'b0;
         dst  <= 4'd0;
         data <= 8'd0;
      end else begin
         we <= wr_en;
         if (wr_en) begin
            dst  <= sel_dst;
            data <= sel_data;
         end
      end
   end

   // FIFO storage, pointers and occupancy; reset discards every pending entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_dst[i] <= 4'd0;
            q_dat[i] <= 8'd0;
         end
      end else begin
         if (push) begin
            q_dst[tail] <= alu_dst;
            q_dat[tail] <= alu_data;
            tail        <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         if (push && !pop) begin
            cnt <= cnt + 1'b1;
         end else if (pop && !push) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   // Forwarding: output register first, then FIFO oldest to youngest so the youngest match wins.
   always_comb begin
      logic [PTR_W:0]   off;
      logic [PTR_W-1:0] idx;
      fwd_hit  = 1'b0;
      fwd_data = 8'd0;
      off      = '0;
      idx      = '0;
      if (we && (dst == fwd_src)) begin
         fwd_hit  = 1'b1;
         fwd_data = data;
      end
      for (int i = 0; i < DEPTH; i++) begin
         off = (PTR_W+1)'(i);
         idx = head + off[PTR_W-1:0];
         if ((off < cnt) && (q_dst[idx] == fwd_src)) begin
            fwd_hit  = 1'b1;
            fwd_data = q_dat[idx];
         end
      end
`ifdef WB_R0_ZERO_EN
      if (fwd_src == 4'd0) begin
         fwd_hit  = 1'b0;
         fwd_data = 8'd0;
      end
`endif
   end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: reset, bypass, load priority, backpressure, forwarding, async reset, r0.
// Inputs driven 1 time unit after the rising edge; outputs sampled at that same point.
// Honours WB_R0_ZERO_EN for the register-0 expectations.
module tb_reg_writeback;

   logic       clk;
   logic       rst_n;
   logic       alu_valid;
   logic       alu_ready;
   logic [3:0] alu_dst;
   logic [7:0] alu_data;
   logic       mem_valid;
   logic [3:0] mem_dst;
   logic [7:0] mem_data;
   logic       we;
   logic [3:0] dst;
   logic [7:0] data;
   logic [3:0] fwd_src;
   logic       fwd_hit;
   logic [7:0] fwd_data;
   logic [2:0] pend_cnt;

   int n_chk;
   int n_pass;

   reg_writeback #(.DEPTH(4), .PTR_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_data(mem_data),
      .we(we), .dst(dst), .data(data),
      .fwd_src(fwd_src), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .pend_cnt(pend_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0;
      mem_valid = 1'b0;
   endtask

   initial begin
      int ai;
      int wi;
      bit acc;
      n_chk     = 0;
      n_pass    = 0;
      rst_n     = 1'b0;
      alu_valid = 1'b0;
      alu_dst   = 4'd0;
      alu_data  = 8'd0;
      mem_valid = 1'b0;
      mem_dst   = 4'd0;
      mem_data  = 8'd0;
      fwd_src   = 4'd3;
      #12;
      check("rst_we", we, 1'b0);
      check("rst_dst", dst, 4'd0);
      check("rst_data", data, 8'd0);
      check("rst_pend", pend_cnt, 3'd0);
      check("rst_rdy", alu_ready, 1'b1);
      check("rst_fhit", fwd_hit, 1'b0);
      check("rst_fdat", fwd_data, 8'd0);
      rst_n = 1'b1;
      step();

      // ALU bypass with empty FIFO
      alu_valid = 1'b1; alu_dst = 4'd3; alu_data = 8'h5A;
      step();
      idle();
      check("byp_we", we, 1'b1);
      check("byp_dst", dst, 4'd3);
      check("byp_data", data, 8'h5A);
      check("byp_pend", pend_cnt, 3'd0);
      check("byp_fwd", fwd_data, 8'h5A);
      step();
      check("idle_we", we, 1'b0);
      check("idle_dst", dst, 4'd3);
      check("idle_data", data, 8'h5A);

      // Load and ALU in the same cycle
      mem_valid = 1'b1; mem_dst = 4'd1; mem_data = 8'h11;
      alu_valid = 1'b1; alu_dst = 4'd2; alu_data = 8'h22;
      step();
      idle();
      check("mix1_dst", dst, 4'd1);
      check("mix1_data", data, 8'h11);
      check("mix1_pend", pend_cnt, 3'd1);
      fwd_src = 4'd2;
      #1 check("mix_fwd_q", {fwd_hit, fwd_data}, {1'b1, 8'h22});
      fwd_src = 4'd1;
      #1 check("mix_fwd_o", {fwd_hit, fwd_data}, {1'b1, 8'h11});
      step();
      check("mix2_we", we, 1'b1);
      check("mix2_dst", dst, 4'd2);
      check("mix2_data", data, 8'h22);
      check("mix2_pend", pend_cnt, 3'd0);
      step();

      // Sustained loads: ALU r4..r9 back up until the FIFO is full
      ai = 0;
      for (int k = 0; k < 6; k++) begin
         mem_valid = 1'b1; mem_dst = 4'd12; mem_data = 8'(k);
         alu_valid = 1'b1; alu_dst = 4'(4 + ai); alu_data = 8'(8'h40 + ai);
         if (k >= 4) check("full_rdy", alu_ready, 1'b0);
         acc = alu_ready;
         step();
         if (acc) ai++;
         check("burst_wr", {we, dst, data}, {1'b1, 4'd12, 8'(k)});
      end
      check("burst_acc", ai, 4);
      check("burst_pend", pend_cnt, 3'd4);
      check("burst_rdy", alu_ready, 1'b0);
      mem_valid = 1'b0;
      wi = 0;
      for (int c = 0; c < 20 && wi < 6; c++) begin
         alu_valid = (ai < 6);
         alu_dst   = 4'(4 + ai);
         alu_data  = 8'(8'h40 + ai);
         acc = alu_valid && alu_ready;
         step();
         if (acc) ai++;
         if (we) begin
            check("drain_wr", {dst, data}, {4'(4 + wi), 8'(8'h40 + wi)});
            wi++;
         end
      end
      idle();
      check("drain_cnt", wi, 6);
      check("drain_pend", pend_cnt, 3'd0);
      step();

      // Forwarding picks the youngest of two queued r5 values
      mem_valid = 1'b1; mem_dst = 4'd12; mem_data = 8'hEE;
      alu_valid = 1'b1; alu_dst = 4'd5; alu_data = 8'h10;
      step();
      alu_data = 8'h20;
      step();
      idle();
      fwd_src = 4'd5;
      #1 check("fwd_r5", {fwd_hit, fwd_data}, {1'b1, 8'h20});
      fwd_src = 4'd6;
      #1 check("fwd_r6", {fwd_hit, fwd_data}, {1'b0, 8'h00});
      step();
      step();
      check("fwd_pend", pend_cnt, 3'd0);
      step();

      // Asynchronous reset with three entries pending
      mem_valid = 1'b1; mem_dst = 4'd12; mem_data = 8'h77;
      alu_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         alu_dst = 4'(4 + k); alu_data = 8'(8'h60 + k);
         step();
      end
      idle();
      fwd_src = 4'd4;
      check("pre_rst_pend", pend_cnt, 3'd3);
      #3 rst_n = 1'b0;
      #1;
      check("arst_we", we, 1'b0);
      check("arst_pend", pend_cnt, 3'd0);
      check("arst_fhit", fwd_hit, 1'b0);
      check("arst_rdy", alu_ready, 1'b1);
      #1 rst_n = 1'b1;
      wi = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (we) wi++;
      end
      check("post_rst_wr", wi, 0);

      // Register 0 write
      alu_valid = 1'b1; alu_dst = 4'd0; alu_data = 8'hFF;
      step();
      idle();
      fwd_src = 4'd0;
`ifdef WB_R0_ZERO_EN
      check("r0_we", we, 1'b0);
      check("r0_rdy", alu_ready, 1'b1);
      check("r0_pend", pend_cnt, 3'd0);
      #1 check("r0_fwd", {fwd_hit, fwd_data}, {1'b0, 8'h00});
`else
      check("r0_we", we, 1'b1);
      check("r0_dst", dst, 4'd0);
      check("r0_data", data, 8'hFF);
      #1 check("r0_fwd", {fwd_hit, fwd_data}, {1'b1, 8'hFF});
`endif
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
